// File: rtl/condicionador_botoes.sv
// Push-button conditioner: 2-FF synchronizer, counter debouncer and a press FSM
// producing a one-cycle play pulse, one-hot/binary codes and a multi-press error.
module condicionador_botoes #(
   parameter int unsigned N_BOTOES        = 4,
   parameter int unsigned DEBOUNCE_CICLOS = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic [N_BOTOES-1:0] botoes_brutos,
   output logic [N_BOTOES-1:0] botoes_limpos,
   output logic                jogada_pulso,
   output logic [N_BOTOES-1:0] jogada_codigo,
   output logic [1:0]          jogada_indice,
   output logic                erro_multiplo,
   output logic [3:0]          db_estado
);

   localparam int unsigned CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam int unsigned PW = $clog2(N_BOTOES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      PRESSIONADO   = 3'd1,
      INVALIDO      = 3'd2,
      ESPERA_SOLTAR = 3'd3
   } estado_t;

   logic [N_BOTOES-1:0] sync1_q, sync2_q;
   logic [N_BOTOES-1:0] cand_q, cand_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_BOTOES-1:0] limpos_q, limpos_d;
   estado_t             estado_q, estado_d;
   logic                pulso_q, pulso_d;
   logic                erro_q, erro_d;
   logic [N_BOTOES-1:0] codigo_q, codigo_d;
   logic [1:0]          indice_q, indice_d;
   logic [PW-1:0]       n_ativos;
   logic [1:0]          idx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         limpos_q <= '0;
         estado_q <= OCIOSO;
         pulso_q  <= 1'b0;
         erro_q   <= 1'b0;
         codigo_q <= '0;
         indice_q <= '0;
      end else begin
         sync1_q  <= botoes_brutos;
         sync2_q  <= sync1_q;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         limpos_q <= limpos_d;
         estado_q <= estado_d;
         pulso_q  <= pulso_d;
         erro_q   <= erro_d;
         codigo_q <= codigo_d;
         indice_q <= indice_d;
      end
   end

   // Any change of the synchronized value restarts the stability count; counter saturates.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      limpos_d = limpos_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_MAX) begin
         limpos_d = cand_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_comb begin
      n_ativos = '0;
      idx      = '0;
      for (int unsigned i = 0; i < N_BOTOES; i++) begin
         if (limpos_q[i]) begin
            n_ativos = n_ativos + PW'(1);
            idx      = 2'(i);
         end
      end
   end

   // Plays are only recognised from idle; every other state just waits for full release.
   always_comb begin
      estado_d = estado_q;
      pulso_d  = 1'b0;
      erro_d   = 1'b0;
      codigo_d = codigo_q;
      indice_d = indice_q;
      case (estado_q)
         OCIOSO: begin
            if (limpos_q != '0) begin
               if (!habilita) begin
                  estado_d = ESPERA_SOLTAR;
               end else if (n_ativos == PW'(1)) begin
                  estado_d = PRESSIONADO;
                  pulso_d  = 1'b1;
                  codigo_d = limpos_q;
                  indice_d = idx;
               end else begin
                  estado_d = INVALIDO;
                  erro_d   = 1'b1;
               end
            end
         end
         PRESSIONADO, INVALIDO, ESPERA_SOLTAR: begin
            if (limpos_q == '0) estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   assign botoes_limpos = limpos_q;
   assign jogada_pulso  = pulso_q;
   assign erro_multiplo = erro_q;
   assign jogada_codigo = codigo_q;
   assign jogada_indice = indice_q;
   assign db_estado     = 4'(estado_q);

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed corner sequences, a vector table and
// randomized presses checked every cycle against a sliding-window reference model.
module tb_condicionador_botoes;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       habilita;
   logic [3:0] botoes_brutos;
   logic [3:0] botoes_limpos;
   logic       jogada_pulso;
   logic [3:0] jogada_codigo;
   logic [1:0] jogada_indice;
   logic       erro_multiplo;
   logic [3:0] db_estado;

   int n_checks = 0;
   int n_fail   = 0;

   condicionador_botoes #(.N_BOTOES(4), .DEBOUNCE_CICLOS(D)) dut (
      .clock         (clock),
      .reset         (reset),
      .habilita      (habilita),
      .botoes_brutos (botoes_brutos),
      .botoes_limpos (botoes_limpos),
      .jogada_pulso  (jogada_pulso),
      .jogada_codigo (jogada_codigo),
      .jogada_indice (jogada_indice),
      .erro_multiplo (erro_multiplo),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string nome, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
      end
   endtask

   // Reference model: the filtered level takes the raw sample from two edges ago once
   // the last D+1 raw samples (excluding the two newest) all agree.
   logic [3:0] hist[$];
   logic [3:0] m_limpos = '0;
   logic [3:0] m_codigo = '0;
   logic [1:0] m_indice = '0;
   logic       m_pulse  = 1'b0;
   logic       m_err    = 1'b0;
   int         m_state  = 0;

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back(4'b0000);
      m_limpos = '0; m_codigo = '0; m_indice = '0;
      m_pulse = 1'b0; m_err = 1'b0; m_state = 0;
   endtask

   task automatic model_step();
      logic [3:0] prev;
      int         ones;
      bit         estavel;
      prev = m_limpos;
      hist.push_back(botoes_brutos);
      while (hist.size() > D + 3) void'(hist.pop_front());
      estavel = 1'b1;
      for (int i = 1; i <= D; i++) if (hist[i] != hist[0]) estavel = 1'b0;
      if (estavel) m_limpos = hist[0];
      m_pulse = 1'b0;
      m_err   = 1'b0;
      ones    = $countones(prev);
      if (m_state == 0) begin
         if (ones != 0) begin
            if (!habilita) m_state = 3;
            else if (ones == 1) begin
               m_state  = 1;
               m_pulse  = 1'b1;
               m_codigo = prev;
               for (int i = 0; i < 4; i++) if (prev[i]) m_indice = 2'(i);
            end else begin
               m_state = 2;
               m_err   = 1'b1;
            end
         end
      end else if (prev == 4'b0000) begin
         m_state = 0;
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) model_clear();
      else        model_step();
   end

   always @(negedge clock) begin
      check("limpos", 8'(botoes_limpos), 8'(m_limpos));
      check("pulso",  8'(jogada_pulso),  8'(m_pulse));
      check("erro",   8'(erro_multiplo), 8'(m_err));
      check("codigo", 8'(jogada_codigo), 8'(m_codigo));
      check("indice", 8'(jogada_indice), 8'(m_indice));
      check("estado", 8'(db_estado),     8'(m_state));
      check("pulso_e_erro", 8'(jogada_pulso & erro_multiplo), 8'd0);
   end

   typedef struct {
      logic [3:0] raw;
      logic       hab;
      int         ciclos;
      int         exp_pulsos;
      int         exp_erros;
      logic [3:0] exp_estado;
      logic [3:0] exp_codigo;
   } vec_t;

   vec_t tab[12];

   task automatic check_zero(input string tag);
      check({tag, "_limpos"}, 8'(botoes_limpos), 8'd0);
      check({tag, "_pulso"},  8'(jogada_pulso),  8'd0);
      check({tag, "_erro"},   8'(erro_multiplo), 8'd0);
      check({tag, "_codigo"}, 8'(jogada_codigo), 8'd0);
      check({tag, "_indice"}, 8'(jogada_indice), 8'd0);
      check({tag, "_estado"}, 8'(db_estado),     8'd0);
   endtask

   initial begin
      int np, ne, first;
      tab[0]  = '{4'b0010, 1'b1, 12, 1, 0, 4'd1, 4'b0010};
      tab[1]  = '{4'b1010, 1'b1, 12, 0, 0, 4'd1, 4'b0010};
      tab[2]  = '{4'b0000, 1'b1, 12, 0, 0, 4'd0, 4'b0010};
      tab[3]  = '{4'b1010, 1'b1, 12, 0, 1, 4'd2, 4'b0010};
      tab[4]  = '{4'b0000, 1'b1, 12, 0, 0, 4'd0, 4'b0010};
      tab[5]  = '{4'b0001, 1'b0, 12, 0, 0, 4'd3, 4'b0010};
      tab[6]  = '{4'b0001, 1'b1, 12, 0, 0, 4'd3, 4'b0010};
      tab[7]  = '{4'b0000, 1'b1, 12, 0, 0, 4'd0, 4'b0010};
      tab[8]  = '{4'b0001, 1'b1, 12, 1, 0, 4'd1, 4'b0001};
      tab[9]  = '{4'b0000, 1'b1, 12, 0, 0, 4'd0, 4'b0001};
      tab[10] = '{4'b1000, 1'b1, 12, 1, 0, 4'd1, 4'b1000};
      tab[11] = '{4'b0000, 1'b1, 12, 0, 0, 4'd0, 4'b1000};

      reset = 1'b0; habilita = 1'b1; botoes_brutos = 4'b0100;
      #8;
      check_zero("reset");

      // Release reset between edges; the next rising edge is edge 0.
      @(negedge clock); #2 reset = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clock);
         if (k == 5) check("t1_limpos_e5", 8'(botoes_limpos), 8'h00);
         if (k == 6) begin
            check("t1_limpos_e6", 8'(botoes_limpos), 8'h04);
            check("t1_pulso_e6",  8'(jogada_pulso),  8'h00);
         end
         if (k == 7) begin
            check("t1_pulso_e7",  8'(jogada_pulso),  8'h01);
            check("t1_codigo_e7", 8'(jogada_codigo), 8'h04);
            check("t1_indice_e7", 8'(jogada_indice), 8'h02);
            check("t1_estado_e7", 8'(db_estado),     8'h01);
         end
         if (k == 8) check("t1_pulso_e8", 8'(jogada_pulso), 8'h00);
      end
      botoes_brutos = 4'b0000;
      repeat (12) @(negedge clock);
      check("t1_estado_solto", 8'(db_estado), 8'h00);

      for (int i = 0; i < 12; i++) begin
         botoes_brutos = tab[i].raw;
         habilita      = tab[i].hab;
         np = 0; ne = 0;
         repeat (tab[i].ciclos) begin
            @(negedge clock);
            np += int'(jogada_pulso);
            ne += int'(erro_multiplo);
         end
         check($sformatf("vec%0d_pulsos", i), 8'(np), 8'(tab[i].exp_pulsos));
         check($sformatf("vec%0d_erros", i),  8'(ne), 8'(tab[i].exp_erros));
         check($sformatf("vec%0d_estado", i), 8'(db_estado), 8'(tab[i].exp_estado));
         check($sformatf("vec%0d_codigo", i), 8'(jogada_codigo), 8'(tab[i].exp_codigo));
      end

      // Bounce: 0001/0000 toggling every 2 cycles never satisfies the stability window.
      np = 0;
      for (int c = 0; c < 20; c++) begin
         botoes_brutos = ((c / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
         @(negedge clock);
         np += int'(jogada_pulso);
      end
      check("bounce_pulsos", 8'(np), 8'd0);
      botoes_brutos = 4'b0001;
      np = 0;
      repeat (12) begin
         @(negedge clock);
         np += int'(jogada_pulso);
      end
      check("bounce_hold_pulsos", 8'(np), 8'd1);
      check("bounce_indice", 8'(jogada_indice), 8'd0);
      botoes_brutos = 4'b0000;
      repeat (12) @(negedge clock);

      repeat (60) begin
         botoes_brutos = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         habilita      = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 10)) @(negedge clock);
      end
      botoes_brutos = 4'b0000; habilita = 1'b1;
      repeat (12) @(negedge clock);

      // Async reset while in PRESSIONADO, then release with the button still held.
      botoes_brutos = 4'b0100;
      repeat (12) @(negedge clock);
      check("ar_estado_antes", 8'(db_estado), 8'd1);
      check("ar_codigo_antes", 8'(jogada_codigo), 8'h04);
      #2 reset = 1'b0;
      #1 check_zero("ar");
      @(negedge clock); #2 reset = 1'b1;
      first = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (jogada_pulso && first < 0) first = k;
      end
      check("ar_latencia_pulso", 8'(first), 8'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
